// File: rtl/mac_dot_ctrl_if.sv
// Operand-source / MAC / result bundle seen by the dot-product sequencer.
// The controller is the slave side; the operand source and MAC together form the master side.
interface mac_dot_ctrl_if #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             op_valid;
    logic             op_ready;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [OP_W-1:0]  mac_a;
    logic [OP_W-1:0]  mac_b;
    logic             mac_en;
    logic             mac_clr;
    logic [ACC_W-1:0] mac_c;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result;

    modport slave (
        input  start, len, op_valid, op_a, op_b, mac_c,
        output op_ready, mac_a, mac_b, mac_en, mac_clr, busy, done, result
    );

    modport master (
        output start, len, op_valid, op_a, op_b, mac_c,
        input  op_ready, mac_a, mac_b, mac_en, mac_clr, busy, done, result
    );
endinterface

// File: rtl/mac_dot_ctrl.sv
// Dot-product job sequencer: clears the MAC, streams LEN operand pairs under
// valid/ready, then latches the accumulator and pulses done.
module mac_dot_ctrl #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    mac_dot_ctrl_if.slave  bus_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             beat;

    assign beat = bus_if.op_valid && (state_q == S_RUN);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    cnt_d   = bus_if.len;
                    state_d = S_CLEAR;
                end
            end
            // A zero-length job skips RUN but still reports a (zero) result.
            S_CLEAR: state_d = (cnt_q != '0) ? S_RUN : S_DRAIN;
            S_RUN: begin
                if (beat) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_DRAIN;
                end
            end
            // The last beat's accumulate lands on the edge entering DRAIN, so mac_c is final here.
            S_DRAIN: begin
                result_d = bus_if.mac_c;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.op_ready = (state_q == S_RUN);
    assign bus_if.mac_a    = bus_if.op_a;
    assign bus_if.mac_b    = bus_if.op_b;
    assign bus_if.mac_en   = beat;
    assign bus_if.mac_clr  = reset_i || (state_q == S_CLEAR);
    assign bus_if.busy     = (state_q != S_IDLE);
    assign bus_if.done     = (state_q == S_DONE);
    assign bus_if.result   = result_q;
endmodule
